pipe_round_tracker: RTL

Multi-channel, parametrised successor to the single-channel pipeline round counter. Each channel counts enabled cycles up to a runtime-programmable terminal count, with selectable saturate or wrap behaviour. Terminal-count events are queued per channel and presented to downstream AES pipeline control through a valid/ready event port. It sits between the pipeline stage enables and the round/output sequencing logic.

---
 rtl/pipe_round_tracker_if.sv | 21 ++
 rtl/pipe_round_tracker.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pipe_round_tracker_if.sv
// Event port of pipe_round_tracker: pending-event handshake plus sticky overflow.
// master = tracker (drives events), slave = downstream pipeline control.
interface pipe_round_tracker_if #(
    parameter int CH_IDX_BITS = 2
);
    logic                   evt_valid;
    logic [CH_IDX_BITS-1:0] evt_ch;
    logic                   evt_overflow;
    logic                   evt_ready;
    logic                   ovf_clear;

    modport master (
        output evt_valid, evt_ch, evt_overflow,
        input  evt_ready, ovf_clear
    );

    modport slave (
        input  evt_valid, evt_ch, evt_overflow,
        output evt_ready, ovf_clear
    );
endinterface

// File: rtl/pipe_round_tracker.sv
// pipe_round_tracker: NUM_CH independent round counters sharing one runtime
// terminal count, with saturate/wrap selection. Terminal-count events are
// queued per channel and offered lowest-index-first on a valid/ready port.
// Build option: PIPE_ROUND_TRACKER_EVT_EN builds the pending/overflow logic;
// without it the event port is tied off and only counters/done_flag exist.

// One channel: counter plus terminal compare.
module pipe_round_tracker_lane #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         wrap_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] count_o,
    output logic         done_o,
    output logic         evt_o
);
    logic [W-1:0] count_q, count_d;

    // Next count: clear when idle, step below terminal, otherwise hold/clamp
    // to terminal (saturate) or restart at 0 (wrap). Above-terminal counts
    // only exist after a terminal reload and take the same path.
    always_comb begin
        count_d = count_q;
        if (!en_i)
            count_d = '0;
        else if (count_q < term_i)
            count_d = count_q + 1'b1;
        else
            count_d = wrap_i ? '0 : term_i;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    // Terminal is never 0, so term_i - 1 cannot underflow.
    assign evt_o   = en_i && (count_q == term_i - 1'b1);
    assign done_o  = (count_q == term_i);
    assign count_o = count_q;
endmodule

module pipe_round_tracker #(
    parameter int NUM_CNT_BITS = 6,
    parameter int NUM_TO_COUNT = 30,
    parameter int NUM_CH       = 4,
    parameter int CH_IDX_BITS  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              count_enable_i,
    input  logic                           wrap_mode_i,
    input  logic                           tc_load_i,
    input  logic [NUM_CNT_BITS-1:0]        tc_value_i,
    output logic [NUM_CH-1:0]              done_flag_o,
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out_o,
    pipe_round_tracker_if.master           evt_if
);
    logic [NUM_CNT_BITS-1:0] term_q, term_d;
    logic [NUM_CH-1:0]       evt_hit;

    // A zero terminal load is dropped; counters see the old terminal this cycle.
    always_comb begin
        term_d = term_q;
        if (tc_load_i && (tc_value_i != '0))
            term_d = tc_value_i;
    end

    // Shared terminal-count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) term_q <= NUM_CNT_BITS'(NUM_TO_COUNT);
        else     term_q <= term_d;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        pipe_round_tracker_lane #(.W(NUM_CNT_BITS)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en_i   (count_enable_i[g]),
            .wrap_i (wrap_mode_i),
            .term_i (term_q),
            .count_o(count_out_o[g*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .done_o (done_flag_o[g]),
            .evt_o  (evt_hit[g])
        );
    end

`ifdef PIPE_ROUND_TRACKER_EVT_EN
    logic [NUM_CH-1:0]      pend_q, pend_d, pop;
    logic                   ovf_q, ovf_d, lost;
    logic [CH_IDX_BITS-1:0] ch_sel;

    // Lowest-index pending channel; scanning downwards lets the lowest win.
    always_comb begin
        ch_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pend_q[i]) ch_sel = CH_IDX_BITS'(i);
    end

    // Pop the presented bit, merge new events, flag collisions as lost.
    // A pop and a new event on the same channel re-arm the bit without loss;
    // a fresh loss overrides ovf_clear.
    always_comb begin
        pop = '0;
        if (evt_if.evt_ready && (|pend_q))
            pop = NUM_CH'(1) << ch_sel;
        lost   = |(evt_hit & pend_q & ~pop);
        pend_d = (pend_q & ~pop) | evt_hit;
        ovf_d  = lost | (ovf_q & ~evt_if.ovf_clear);
    end

    // Pending bits and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign evt_if.evt_valid    = |pend_q;
    assign evt_if.evt_ch       = ch_sel;
    assign evt_if.evt_overflow = ovf_q;
`else
    // Event port tied off; handshake inputs and lane events are don't-care.
    logic unused_evt;
    assign unused_evt          = ^{evt_if.evt_ready, evt_if.ovf_clear, evt_hit};
    assign evt_if.evt_valid    = 1'b0;
    assign evt_if.evt_ch       = '0;
    assign evt_if.evt_overflow = 1'b0;
`endif
endmodule
